// File: rtl/pfet_seg_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and helpers for the segmented PMOS driver.
// The analog quantities are piecewise-linear (PWL) values: a level, a slope
// and the time at which the level holds. Combining two PWL values rebases
// both onto the later of their time stamps first.
package pfet_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } seg_state_t;

    // v: level at t0, slope: rate per second, t0: reference time in seconds
    typedef struct {
        real v;
        real slope;
        real t0;
    } pwl;

    localparam pwl PWL_ZERO = '{v: 0.0, slope: 0.0, t0: 0.0};
    localparam pwl PWL_ONE  = '{v: 1.0, slope: 0.0, t0: 0.0};

    // Clamp a requested finger count to the physical number of fingers
    function automatic int sat_code(input int code, input int n);
        return (code > n) ? n : code;
    endfunction

    // Level of a PWL value at time t
    function automatic real pwl_at(input pwl a, input real t);
        return a.v + a.slope * (t - a.t0);
    endfunction

    function automatic pwl pwl_add2(input pwl a, input pwl b);
        pwl  r;
        real t;
        t       = (a.t0 > b.t0) ? a.t0 : b.t0;
        r.v     = pwl_at(a, t) + pwl_at(b, t);
        r.slope = a.slope + b.slope;
        r.t0    = t;
        return r;
    endfunction

    function automatic pwl pwl_add3(input pwl a, input pwl b, input pwl c);
        return pwl_add2(pwl_add2(a, b), c);
    endfunction

    function automatic pwl pwl_neg(input pwl a);
        pwl r;
        r.v     = -a.v;
        r.slope = -a.slope;
        r.t0    = a.t0;
        return r;
    endfunction

    // Gain stage; a zero gain yields an exact zero with no time stamp
    function automatic pwl pwl_scale(input pwl a, input real k);
        pwl r;
        if (k == 0.0) begin
            r = PWL_ZERO;
        end else begin
            r.v     = a.v * k;
            r.slope = a.slope * k;
            r.t0    = a.t0;
        end
        return r;
    endfunction

    // Lower limit at zero, no upper limit. A value sitting exactly on zero
    // keeps its slope only if it is about to rise into the passing region.
    function automatic pwl pwl_limit_min0(input pwl a);
        pwl r;
        if ((a.v > 0.0) || ((a.v == 0.0) && (a.slope > 0.0))) begin
            r = a;
        end else begin
            r.v     = 0.0;
            r.slope = 0.0;
            r.t0    = a.t0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pfet_seg_driver_if.sv
`timescale 1ns/1ps
// Finger-code request bus between the driver-strength logic (master) and
// the segmented device (slave), plus the device status it reports back.
interface pfet_seg_driver_if #(
    parameter int CODE_W = 4
) ();

    logic              en;
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              code_ready;
    logic              busy;
    logic [CODE_W-1:0] seg_on;

    modport master (
        output en,
        output code_in,
        output code_valid,
        input  code_ready,
        input  busy,
        input  seg_on
    );

    modport slave (
        input  en,
        input  code_in,
        input  code_valid,
        output code_ready,
        output busy,
        output seg_on
    );

endinterface

// File: rtl/pfet_seg_ctrl.sv
`timescale 1ns/1ps
// Finger ramp controller: accepts a finger-count request, then walks the
// enabled-finger count toward it one finger every STEP_CYC clocks.
// Dropping en forces a ramp down to zero fingers.
module pfet_seg_ctrl
    import pfet_seg_pkg::*;
#(
    parameter int N_SEG    = 8,
    parameter int STEP_CYC = 4,
    parameter int CODE_W   = $clog2(N_SEG + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    pfet_seg_driver_if.slave  bus
);

    localparam int                CNT_W     = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CODE_W-1:0] SEG_MAX   = CODE_W'(N_SEG);

    seg_state_t        state_reg, state_next;
    logic [CODE_W-1:0] target_reg, target_next;
    logic [CODE_W-1:0] seg_on_reg, seg_on_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              code_ready_reg, code_ready_next;

    logic              xfer;
    logic              step_done;
    logic [CODE_W-1:0] sat_target;

    assign xfer       = bus.code_valid && code_ready_reg;
    assign step_done  = (cnt_reg == STEP_LAST);
    assign sat_target = CODE_W'(sat_code(int'(bus.code_in), N_SEG));

    // State register; reset drops fingers immediately, no ramp-down
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            seg_on_reg     <= '0;
            cnt_reg        <= '0;
            code_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            seg_on_reg     <= seg_on_next;
            cnt_reg        <= cnt_next;
            code_ready_reg <= code_ready_next;
        end
    end

    // Next-state logic: request capture, step timer and finger stepping
    always_comb begin
        state_next      = state_reg;
        target_next     = target_reg;
        seg_on_next     = seg_on_reg;
        cnt_next        = cnt_reg;
        code_ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!bus.en) begin
                    target_next = '0;
                    if (seg_on_reg != '0) begin
                        state_next = DN;
                    end
                end else if (xfer) begin
                    target_next = sat_target;
                    if (sat_target > seg_on_reg) begin
                        state_next = UP;
                    end else if (sat_target < seg_on_reg) begin
                        state_next = DN;
                    end
                end
            end

            UP: begin
                if (!bus.en) begin
                    // Reverse direction with a fresh step period
                    target_next = '0;
                    state_next  = DN;
                    cnt_next    = '0;
                end else if (step_done) begin
                    cnt_next = '0;
                    if (seg_on_reg < SEG_MAX) begin
                        seg_on_next = seg_on_reg + 1'b1;
                    end
                    if (seg_on_next >= target_reg) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DN: begin
                if (!bus.en) begin
                    target_next = '0;
                end
                if (step_done) begin
                    cnt_next = '0;
                    if (seg_on_reg != '0) begin
                        seg_on_next = seg_on_reg - 1'b1;
                    end
                    if (seg_on_next <= target_next) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Ready is offered only when the controller will sit idle next cycle
        code_ready_next = bus.en && (state_next == IDLE);
    end

    assign bus.code_ready = code_ready_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.seg_on     = seg_on_reg;

endmodule

// File: rtl/pfet_seg_driver.sv
`timescale 1ns/1ps
// Segmented PMOS DC I-V model. N_SEG identical fingers share d/g/s and the
// controller enables them one at a time, so the drain current slews in
// per-finger steps:
//   id = seg_on * gm_unit * (max(s-g-|VTH|,0) - max(d-g-|VTH|,0))
module pfet_seg_driver
    import pfet_seg_pkg::*;
#(
    parameter real VTH      = 0.4,
    parameter int  N_SEG    = 8,
    parameter int  STEP_CYC = 4
) (
    input  logic             clk,
    input  logic             rstn,
    pfet_seg_driver_if.slave bus,
    input  real              gm_unit,
    input  pwl               d,
    input  pwl               g,
    input  pwl               s,
    output pwl               id
);

    localparam int  CODE_W  = $clog2(N_SEG + 1);
    localparam real VTH_ABS = (VTH < 0.0) ? -VTH : VTH;

    pfet_seg_ctrl #(
        .N_SEG    (N_SEG),
        .STEP_CYC (STEP_CYC),
        .CODE_W   (CODE_W)
    ) u_ctrl (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    pwl  neg_g;
    pwl  vth_pwl;
    pwl  vsg_raw;
    pwl  vdg_raw;
    pwl  vsg0;
    pwl  vdg0;
    pwl  vov;
    real scale;

    // Overdrive of each channel end, clamped at cut-off, then the
    // difference scaled by the number of fingers currently conducting
    always_comb begin
        neg_g   = pwl_neg(g);
        vth_pwl = pwl_scale(PWL_ONE, -VTH_ABS);
        vsg_raw = pwl_add3(s, neg_g, vth_pwl);
        vdg_raw = pwl_add3(d, neg_g, vth_pwl);
        vsg0    = pwl_limit_min0(vsg_raw);
        vdg0    = pwl_limit_min0(vdg_raw);
        vov     = pwl_add2(vsg0, pwl_neg(vdg0));
        scale   = real'(bus.seg_on) * gm_unit;
        id      = pwl_scale(vov, scale);
    end

endmodule

// File: tb/tb_pfet_seg_driver.sv
`timescale 1ns/1ps
// Directed bench for the segmented PMOS driver: reset, ramp latency,
// saturation, drain sweep, en-forced ramp-down and mid-ramp reset.
module tb_pfet_seg_driver;
    import pfet_seg_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    real  gm_unit;
    pwl   d, g, s, id;

    int n_cmp = 0;
    int n_err = 0;

    pfet_seg_driver_if #(.CODE_W(4)) bus ();

    pfet_seg_driver #(
        .VTH      (0.4),
        .N_SEG    (8),
        .STEP_CYC (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .gm_unit (gm_unit),
        .d       (d),
        .g       (g),
        .s       (s),
        .id      (id)
    );

    always #5 clk = ~clk;

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Advance one clock and land on the following falling edge
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one code for a single edge (caller ensures code_ready)
    task automatic send_code(input int c);
        bus.code_in    = 4'(c);
        bus.code_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        $display("xfer code=%0d at %0t", c, $time);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (bus.seg_on !== 4'd0) begin n_err++; $display("FAIL rst_seg i=%0d got %0d want 0", i, bus.seg_on); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy i=%0d got %b want 0", i, bus.busy); end
            n_cmp++; if (bus.code_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready i=%0d got %b want 0", i, bus.code_ready); end
            n_cmp++; if (rabs(id.v) > 1e-12) begin n_err++; $display("FAIL rst_id i=%0d got %g want 0", i, id.v); end
        end
        rstn = 1'b1;
        cycle();
        n_cmp++; if (bus.code_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b want 1", bus.code_ready); end
        n_cmp++; if (bus.seg_on !== 4'd0) begin n_err++; $display("FAIL rel_seg got %0d want 0", bus.seg_on); end
        $display("reset done");
    endtask

    task automatic test_code3();
        logic [3:0] exp_seg;
        logic       exp_busy;
        send_code(3);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            exp_seg  = 4'(k / 4);
            exp_busy = (k < 12);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL c3_seg k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL c3_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
            n_cmp++; if (bus.code_ready !== !exp_busy) begin n_err++; $display("FAIL c3_ready k=%0d got %b want %b", k, bus.code_ready, !exp_busy); end
            n_cmp++; if (rabs(id.v - real'(k / 4) * 0.6e-3) > 1e-9) begin n_err++; $display("FAIL c3_id k=%0d got %g want %g", k, id.v, real'(k / 4) * 0.6e-3); end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_seg;
        logic       exp_busy;
        rstn = 1'b0;
        cycle();
        n_cmp++; if (bus.seg_on !== 4'd0) begin n_err++; $display("FAIL sat_rst_seg got %0d want 0", bus.seg_on); end
        rstn = 1'b1;
        cycle();
        bus.code_in    = 4'd15;
        bus.code_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("xfer code=15 at %0t", $time);
        bus.code_in = 4'd2;  // held valid while busy: must be ignored
        for (int k = 1; k <= 32; k++) begin
            cycle();
            exp_seg  = 4'(k / 4);
            exp_busy = (k < 32);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL sat_seg k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL sat_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
            n_cmp++; if (bus.code_ready !== !exp_busy) begin n_err++; $display("FAIL sat_ready k=%0d got %b want %b", k, bus.code_ready, !exp_busy); end
            if (k == 31) bus.code_valid = 1'b0;
        end
        n_cmp++; if (rabs(id.v - 4.8e-3) > 1e-9) begin n_err++; $display("FAIL sat_id got %g want 4.8e-3", id.v); end
    endtask

    task automatic test_d_ramp();
        real dv[5]  = '{0.0, 0.2, 0.4, 0.7, 1.0};
        real slp[5] = '{1.0e6, 1.0e6, 1.0e6, 1.0e6, 0.0};
        real exp_v, exp_s, ov;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d = '{v: dv[i], slope: slp[i], t0: $realtime * 1.0e-9};
            #1;
            ov    = (dv[i] - 0.4 > 0.0) ? dv[i] - 0.4 : 0.0;
            exp_v = 8.0e-3 * (0.6 - ov);
            exp_s = (dv[i] >= 0.4 && slp[i] > 0.0) ? -8.0e3 : 0.0;
            $display("d step v=%g slope=%g", dv[i], slp[i]);
            n_cmp++; if (rabs(id.v - exp_v) > 1e-9) begin n_err++; $display("FAIL dr_id i=%0d got %g want %g", i, id.v, exp_v); end
            n_cmp++; if (rabs(id.slope - exp_s) > 1e-3) begin n_err++; $display("FAIL dr_slope i=%0d got %g want %g", i, id.slope, exp_s); end
            n_cmp++; if (bus.seg_on !== 4'd8) begin n_err++; $display("FAIL dr_seg i=%0d got %0d want 8", i, bus.seg_on); end
        end
        repeat (3) cycle();
        n_cmp++; if (bus.seg_on !== 4'd8 || bus.busy !== 1'b0) begin n_err++; $display("FAIL dr_hold got seg=%0d busy=%b want seg=8 busy=0", bus.seg_on, bus.busy); end
        d = '{v: 0.0, slope: 0.0, t0: 0.0};
        #1;
        n_cmp++; if (rabs(id.v - 4.8e-3) > 1e-9) begin n_err++; $display("FAIL dr_restore got %g want 4.8e-3", id.v); end
    endtask

    task automatic test_en_off();
        logic [3:0] exp_seg;
        logic       exp_busy;
        @(negedge clk);
        send_code(5);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            exp_seg = 4'(8 - k / 4);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL dn5_seg k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
        end
        bus.en = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            cycle();
            exp_seg  = 4'(5 - j / 4);
            exp_busy = (j < 20);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL enoff_seg j=%0d got %0d want %0d", j, bus.seg_on, exp_seg); end
            n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL enoff_busy j=%0d got %b want %b", j, bus.busy, exp_busy); end
            n_cmp++; if (bus.code_ready !== 1'b0) begin n_err++; $display("FAIL enoff_ready j=%0d got %b want 0", j, bus.code_ready); end
        end
        bus.en = 1'b1;
        cycle();
        n_cmp++; if (bus.code_ready !== 1'b1) begin n_err++; $display("FAIL enon_ready got %b want 1", bus.code_ready); end
        n_cmp++; if (rabs(id.v) > 1e-12) begin n_err++; $display("FAIL enon_id got %g want 0", id.v); end
    endtask

    task automatic test_en_fall_up();
        logic [3:0] exp_seg;
        send_code(4);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            exp_seg = 4'(k / 4);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL efu_up k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
        end
        bus.en = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            cycle();
            exp_seg = (j < 4) ? 4'd1 : 4'd0;
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL efu_dn j=%0d got %0d want %0d", j, bus.seg_on, exp_seg); end
            n_cmp++; if (bus.busy !== (j < 4)) begin n_err++; $display("FAIL efu_busy j=%0d got %b want %b", j, bus.busy, (j < 4)); end
        end
        bus.en = 1'b1;
        cycle();
    endtask

    task automatic test_rst_midramp();
        logic [3:0] exp_seg;
        send_code(6);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            exp_seg = 4'(k / 4);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL mr_up k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
        end
        rstn = 1'b0;
        cycle();
        n_cmp++; if (bus.seg_on !== 4'd0) begin n_err++; $display("FAIL mr_seg got %0d want 0", bus.seg_on); end
        n_cmp++; if (rabs(id.v) > 1e-12) begin n_err++; $display("FAIL mr_id got %g want 0", id.v); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mr_busy got %b want 0", bus.busy); end
        rstn = 1'b1;
        cycle();
        n_cmp++; if (bus.code_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready got %b want 1", bus.code_ready); end
        send_code(1);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            exp_seg = 4'(k / 4);
            n_cmp++; if (bus.seg_on !== exp_seg) begin n_err++; $display("FAIL mr_new k=%0d got %0d want %0d", k, bus.seg_on, exp_seg); end
            n_cmp++; if (bus.busy !== (k < 4)) begin n_err++; $display("FAIL mr_nbusy k=%0d got %b want %b", k, bus.busy, (k < 4)); end
        end
    endtask

    task automatic test_same_code();
        send_code(1);
        for (int k = 1; k <= 2; k++) begin
            cycle();
            n_cmp++; if (bus.busy !== 1'b0 || bus.code_ready !== 1'b1) begin n_err++; $display("FAIL same k=%0d got busy=%b ready=%b want busy=0 ready=1", k, bus.busy, bus.code_ready); end
            n_cmp++; if (bus.seg_on !== 4'd1) begin n_err++; $display("FAIL same_seg k=%0d got %0d want 1", k, bus.seg_on); end
        end
    endtask

    initial begin
        bus.en         = 1'b1;
        bus.code_in    = 4'd0;
        bus.code_valid = 1'b0;
        gm_unit        = 1.0e-3;
        s              = '{v: 1.0, slope: 0.0, t0: 0.0};
        g              = '{v: 0.0, slope: 0.0, t0: 0.0};
        d              = '{v: 0.0, slope: 0.0, t0: 0.0};
        test_reset();
        test_code3();
        test_saturate();
        test_d_ramp();
        test_en_off();
        test_en_fall_up();
        test_rst_midramp();
        test_same_code();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
